xgmii_rx_decap: RTL

XGMII_RX_DECAP -- requirements
Module: xgmii_rx_decap

---
 rtl/xgmii_rx_decap.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/xgmii_rx_decap.sv
// rtl/xgmii_rx_decap.sv - XGMII receive decapsulator: filters tunnelled UDP frames, checks FCS
// and writes 64-bit TLP words with start/last/error flags into a FIFO.
module xgmii_rx_decap #(
   parameter logic [31:0] MAGIC_CODE     = 32'h7e1c_0de5,
   parameter logic [15:0] UDP_PORT       = 16'h0d5e,
   parameter int          MAX_DATA_WORDS = 40
) (
   input  logic        xgmii_clk,
   input  logic        sys_rst_n,
   input  logic [71:0] xgmii_rxd,
   input  logic [47:0] if_macaddr,
   input  logic [31:0] if_v4addr,
   output logic [71:0] din,
   output logic        wr_en,
   input  logic        full,
   output logic [31:0] rx_good_cnt,
   output logic [31:0] rx_drop_cnt,
   output logic [31:0] rx_crc_err_cnt,
   output logic        rx_overflow
);
   localparam logic [71:0] W0_PATTERN = 72'h01_d555_5555_5555_55fb;
   localparam int          CW         = $clog2(MAX_DATA_WORDS + 1);
   localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_DATA_WORDS);

   typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_t;
   state_t state, state_nxt;

   logic [7:0]    rxc;
   logic [63:0]   rxd;
   logic [2:0]    hdr_idx;
   logic [31:0]   crc;
   logic [63:0]   hold_data;
   logic          hold_vld;
   logic          first_pend;
   logic [CW-1:0] data_cnt;
   logic [47:0]   mac_wire;

   logic is_w0, is_term, has_fd, hdr_ok, crc_ok;
   logic start_frame, crc_upd, hdr_adv, hold_load, hold_clr;
   logic wr, wr_last, wr_err, inc_good, inc_drop, inc_crc, set_ovf;

   assign rxc = xgmii_rxd[71:64];
   assign rxd = xgmii_rxd[63:0];

   // Lane 0 carries the first byte on the wire, i.e. the MSB of the address.
   assign mac_wire = {if_macaddr[7:0], if_macaddr[15:8], if_macaddr[23:16],
                      if_macaddr[31:24], if_macaddr[39:32], if_macaddr[47:40]};

   // Reflected Ethernet CRC-32, lane 0 first, LSB first within each byte.
   function automatic logic [31:0] crc32_d64(input logic [63:0] d, input logic [31:0] c);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 64; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hedb8_8320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   assign is_w0   = (xgmii_rxd == W0_PATTERN);
   assign is_term = (rxc == 8'hf0) && (rxd[63:32] == 32'h0707_07fd);
   assign crc_ok  = (rxd[31:0] == ~crc);

   always_comb begin
      has_fd = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (rxc[i] && (rxd[8*i +: 8] == 8'hfd)) has_fd = 1'b1;
      end
   end

   always_comb begin
      hdr_ok = 1'b0;
      case (hdr_idx)
         3'd1: hdr_ok = (rxd[47:0] == mac_wire) || (rxd[47:0] == 48'hffff_ffff_ffff);
         3'd2: hdr_ok = (rxd[39:32] == 8'h08) && (rxd[47:40] == 8'h00) && (rxd[55:48] == 8'h45);
         3'd3: hdr_ok = (rxd[63:56] == 8'h11);
         3'd4: hdr_ok = (rxd[63:48] == {if_v4addr[23:16], if_v4addr[31:24]});
         3'd5: hdr_ok = (rxd[15:0] == {if_v4addr[7:0], if_v4addr[15:8]}) &&
                        (rxd[47:32] == {UDP_PORT[7:0], UDP_PORT[15:8]});
         3'd6: hdr_ok = (rxd[47:16] == {MAGIC_CODE[7:0], MAGIC_CODE[15:8],
                                        MAGIC_CODE[23:16], MAGIC_CODE[31:24]});
         default: hdr_ok = 1'b0;
      endcase
   end

   always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      start_frame = 1'b0;
      crc_upd     = 1'b0;
      hdr_adv     = 1'b0;
      hold_load   = 1'b0;
      hold_clr    = 1'b0;
      wr          = 1'b0;
      wr_last     = 1'b0;
      wr_err      = 1'b0;
      inc_good    = 1'b0;
      inc_drop    = 1'b0;
      inc_crc     = 1'b0;
      set_ovf     = 1'b0;
      case (state)
         IDLE: begin
            if (is_w0) begin
               state_nxt   = HDR;
               start_frame = 1'b1;
            end
         end
         HDR: begin
            if ((rxc != 8'h00) || !hdr_ok) begin
               inc_drop  = 1'b1;
               state_nxt = has_fd ? IDLE : DROP;
            end else begin
               crc_upd = 1'b1;
               if (hdr_idx == 3'd6) begin
                  if (full) begin
                     inc_drop  = 1'b1;
                     state_nxt = DROP;
                  end else begin
                     state_nxt = DATA;
                  end
               end else begin
                  hdr_adv = 1'b1;
               end
            end
         end
         DATA: begin
            if ((rxc == 8'h00) && (data_cnt != MAX_CNT)) begin
               if (hold_vld && full) begin
                  set_ovf   = 1'b1;
                  inc_crc   = 1'b1;
                  hold_clr  = 1'b1;
                  state_nxt = DROP;
               end else begin
                  wr        = hold_vld;
                  hold_load = 1'b1;
                  crc_upd   = 1'b1;
               end
            end else begin
               // Frame closes here: clean terminate, bad control, oversize or a new W0.
               hold_clr = 1'b1;
               if (!hold_vld) begin
                  inc_drop = 1'b1;
               end else if (full) begin
                  set_ovf = 1'b1;
                  inc_crc = 1'b1;
               end else begin
                  wr      = 1'b1;
                  wr_last = 1'b1;
                  if (is_term && crc_ok) begin
                     inc_good = 1'b1;
                  end else begin
                     wr_err  = 1'b1;
                     inc_crc = 1'b1;
                  end
               end
               if (is_w0) begin
                  state_nxt   = HDR;
                  start_frame = 1'b1;
               end else if (has_fd) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = DROP;
               end
            end
         end
         DROP: begin
            if (has_fd) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         din            <= '0;
         wr_en          <= 1'b0;
         crc            <= '1;
         hdr_idx        <= '0;
         data_cnt       <= '0;
         hold_data      <= '0;
         hold_vld       <= 1'b0;
         first_pend     <= 1'b0;
         rx_good_cnt    <= '0;
         rx_drop_cnt    <= '0;
         rx_crc_err_cnt <= '0;
         rx_overflow    <= 1'b0;
      end else begin
         wr_en <= wr;
         if (wr) din <= {3'b000, wr_err, 1'b1, 1'b1, wr_last, first_pend, hold_data};
         if (start_frame) begin
            crc      <= '1;
            hdr_idx  <= 3'd1;
            data_cnt <= '0;
         end else begin
            if (crc_upd)   crc      <= crc32_d64(rxd, crc);
            if (hdr_adv)   hdr_idx  <= hdr_idx + 3'd1;
            if (hold_load) data_cnt <= data_cnt + 1'b1;
         end
         if (start_frame) first_pend <= 1'b1;
         else if (wr)     first_pend <= 1'b0;
         if (hold_load) begin
            hold_data <= rxd;
            hold_vld  <= 1'b1;
         end else if (hold_clr) begin
            hold_vld <= 1'b0;
         end
         if (inc_good) rx_good_cnt    <= rx_good_cnt + 32'd1;
         if (inc_drop) rx_drop_cnt    <= rx_drop_cnt + 32'd1;
         if (inc_crc)  rx_crc_err_cnt <= rx_crc_err_cnt + 32'd1;
         if (set_ovf)  rx_overflow    <= 1'b1;
      end
   end
endmodule
